// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// around the ihit/dhit handshake, with per-access timeout, illegal-instruction trap and sticky halt.
module multicycle_control_unit #(
  parameter int AOP_W        = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             CLK_i,
  input  logic             nRST_i,
  input  logic [31:0]      instr_i,
  input  logic             ihit_i,
  input  logic             dhit_i,
  input  logic             zero_i,
  output logic             iREN_o,
  output logic             dREN_o,
  output logic             dWEN_o,
  output logic             IRWr_o,
  output logic             PCWr_o,
  output logic [1:0]       PCsrc_o,
  output logic [AOP_W-1:0] alu_op_o,
  output logic [1:0]       ALUsrc_o,
  output logic             ExtOp_o,
  output logic             LUI_o,
  output logic [1:0]       RegDst_o,
  output logic             RegWr_o,
  output logic             MemToReg_o,
  output logic             halt_o,
  output logic [1:0]       err_o
);

  localparam int CNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08, FN_ADDU = 6'h21,
                         FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR  = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  localparam logic [AOP_W-1:0] ALU_SLL = AOP_W'(0), ALU_SRL = AOP_W'(1), ALU_ADD = AOP_W'(2),
                               ALU_SUB = AOP_W'(3), ALU_AND = AOP_W'(4), ALU_OR  = AOP_W'(5),
                               ALU_XOR = AOP_W'(6), ALU_NOR = AOP_W'(7), ALU_SLT = AOP_W'(8),
                               ALU_SLTU = AOP_W'(9);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, ERR} state_t;

  state_t           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d, funct_q, funct_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic             legal, isHalt, isJ, isJal, isBeq, isBne, isJr, isLw, isSw, isLui, isRtype;
  logic [AOP_W-1:0] aluSel;
  logic [1:0]       srcSel;
  logic             extSel;
  logic             timeout;
  logic             unused_instr;

  // Only opcode and funct steer the sequence; register fields go straight to the datapath.
  assign unused_instr = ^instr_i[25:6];
  assign timeout      = (MEM_WAIT_MAX != 0) && (wait_cnt_q == CNT_W'(MEM_WAIT_MAX));

  always_comb begin
    legal   = 1'b1;
    isHalt  = 1'b0;
    isJ     = 1'b0;
    isJal   = 1'b0;
    isBeq   = 1'b0;
    isBne   = 1'b0;
    isJr    = 1'b0;
    isLw    = 1'b0;
    isSw    = 1'b0;
    isLui   = 1'b0;
    isRtype = (opcode_q == OP_RTYPE);
    aluSel  = ALU_ADD;
    srcSel  = 2'b01;
    extSel  = 1'b0;
    case (opcode_q)
      OP_RTYPE: begin
        srcSel = 2'b00;
        case (funct_q)
          FN_SLL:  begin aluSel = ALU_SLL; srcSel = 2'b10; end
          FN_SRL:  begin aluSel = ALU_SRL; srcSel = 2'b10; end
          FN_JR:   isJr = 1'b1;
          FN_ADDU: aluSel = ALU_ADD;
          FN_SUBU: aluSel = ALU_SUB;
          FN_AND:  aluSel = ALU_AND;
          FN_OR:   aluSel = ALU_OR;
          FN_XOR:  aluSel = ALU_XOR;
          FN_NOR:  aluSel = ALU_NOR;
          FN_SLT:  aluSel = ALU_SLT;
          FN_SLTU: aluSel = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDIU: extSel = 1'b1;
      OP_SLTI:  begin aluSel = ALU_SLT;  extSel = 1'b1; end
      OP_SLTIU: begin aluSel = ALU_SLTU; extSel = 1'b1; end
      OP_ANDI:  aluSel = ALU_AND;
      OP_ORI:   aluSel = ALU_OR;
      OP_XORI:  aluSel = ALU_XOR;
      OP_LUI:   isLui = 1'b1;
      OP_BEQ:   begin isBeq = 1'b1; aluSel = ALU_SUB; srcSel = 2'b00; extSel = 1'b1; end
      OP_BNE:   begin isBne = 1'b1; aluSel = ALU_SUB; srcSel = 2'b00; extSel = 1'b1; end
      OP_LW:    begin isLw = 1'b1; extSel = 1'b1; end
      OP_SW:    begin isSw = 1'b1; extSel = 1'b1; end
      OP_J:     isJ = 1'b1;
      OP_JAL:   isJal = 1'b1;
      OP_HALT:  isHalt = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    funct_d    = funct_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    iREN_o     = 1'b0;
    dREN_o     = 1'b0;
    dWEN_o     = 1'b0;
    IRWr_o     = 1'b0;
    PCWr_o     = 1'b0;
    PCsrc_o    = 2'b00;
    alu_op_o   = '0;
    ALUsrc_o   = 2'b00;
    ExtOp_o    = 1'b0;
    LUI_o      = 1'b0;
    RegDst_o   = 2'b00;
    RegWr_o    = 1'b0;
    MemToReg_o = 1'b0;
    halt_o     = 1'b0;
    err_o      = err_q;
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      alu_op_o = aluSel;
      ALUsrc_o = srcSel;
      ExtOp_o  = extSel;
    end
    case (state_q)
      FETCH: begin
        iREN_o = 1'b1;
        if (ihit_i) begin
          IRWr_o   = 1'b1;
          PCWr_o   = 1'b1;
          opcode_d = instr_i[31:26];
          funct_d  = instr_i[5:0];
          state_d  = DECODE;
        end else if (timeout) begin
          state_d = ERR;
          err_d   = 2'b01;
        end
      end
      DECODE: begin
        if (!legal) begin
          state_d = ERR;
          err_d   = 2'b11;
        end else if (isHalt) begin
          state_d = HALT;
        end else if (isJ || isJal) begin
          PCWr_o   = 1'b1;
          PCsrc_o  = 2'b10;
          RegWr_o  = isJal;
          RegDst_o = isJal ? 2'b10 : 2'b00;
          state_d  = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (isBeq || isBne) begin
          PCWr_o  = (zero_i == isBeq);
          PCsrc_o = 2'b01;
          state_d = FETCH;
        end else if (isJr) begin
          PCWr_o  = 1'b1;
          PCsrc_o = 2'b11;
          state_d = FETCH;
        end else begin
          state_d = (isLw || isSw) ? MEM : WB;
        end
      end
      MEM: begin
        dREN_o = isLw;
        dWEN_o = isSw;
        if (dhit_i) begin
          state_d = isLw ? WB : FETCH;
        end else if (timeout) begin
          state_d = ERR;
          err_d   = 2'b10;
        end
      end
      WB: begin
        RegWr_o    = 1'b1;
        RegDst_o   = isRtype ? 2'b01 : 2'b00;
        MemToReg_o = isLw;
        LUI_o      = isLui;
        state_d    = FETCH;
      end
      HALT, ERR: halt_o = 1'b1;
      default:   state_d = FETCH;
    endcase
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if ((state_q == FETCH && !ihit_i) || (state_q == MEM && !dhit_i)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK_i) begin
    if (!nRST_i) begin
      state_q    <= FETCH;
      opcode_q   <= '0;
      funct_q    <= '0;
      err_q      <= 2'b00;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      funct_q    <= funct_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction cycle traces are derived from an ISA table and the
// phase rules of the control unit, then compared cycle by cycle against the DUT outputs.
module tb_multicycle_control_unit;

  localparam int LIMIT = 15;
  localparam int ABSORB_CYCLES = 5;

  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                         ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
  localparam logic [3:0] K_ALU = 4'd0, K_LUI = 4'd1, K_LW = 4'd2, K_SW = 4'd3, K_BEQ = 4'd4,
                         K_BNE = 4'd5, K_JR = 4'd6, K_J = 4'd7, K_JAL = 4'd8, K_HALT = 4'd9,
                         K_ILL = 4'd10;

  typedef struct packed {
    logic       iREN, dREN, dWEN, IRWr, PCWr;
    logic [1:0] PCsrc;
    logic [3:0] aluOp;
    logic [1:0] aluSrc;
    logic       extOp, lui;
    logic [1:0] regDst;
    logic       regWr, memToReg, halt;
    logic [1:0] err;
  } ctrl_t;

  typedef struct packed {
    logic        rstn, ihit, dhit, zero;
    logic [31:0] instr;
    ctrl_t       exp;
  } step_t;

  typedef struct packed {
    logic [5:0] opc, fn;
    logic [3:0] kind, alu;
    logic [1:0] src;
    logic       ext;
  } isa_t;

  logic        clk = 1'b0, nRst = 1'b0, ihit = 1'b0, dhit = 1'b0, zero = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        iREN, dREN, dWEN, IRWr, PCWr, extOp, lui, regWr, memToReg, halt;
  logic [1:0]  PCsrc, aluSrc, regDst, err;
  logic [3:0]  aluOp;
  ctrl_t       obs;

  int     compared = 0;
  int     mismatched = 0;
  step_t  plan[$];
  isa_t   isa[$];

  multicycle_control_unit #(.AOP_W(4), .MEM_WAIT_MAX(LIMIT)) dut (
    .CLK_i(clk), .nRST_i(nRst), .instr_i(instr), .ihit_i(ihit), .dhit_i(dhit), .zero_i(zero),
    .iREN_o(iREN), .dREN_o(dREN), .dWEN_o(dWEN), .IRWr_o(IRWr), .PCWr_o(PCWr),
    .PCsrc_o(PCsrc), .alu_op_o(aluOp), .ALUsrc_o(aluSrc), .ExtOp_o(extOp), .LUI_o(lui),
    .RegDst_o(regDst), .RegWr_o(regWr), .MemToReg_o(memToReg), .halt_o(halt), .err_o(err)
  );

  assign obs = {iREN, dREN, dWEN, IRWr, PCWr, PCsrc, aluOp, aluSrc, extOp, lui,
                regDst, regWr, memToReg, halt, err};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic addIsa(input logic [5:0] opc, input logic [5:0] fn, input logic [3:0] kind,
                        input logic [3:0] alu, input logic [1:0] src, input logic ext);
    isa_t e;
    e.opc = opc; e.fn = fn; e.kind = kind; e.alu = alu; e.src = src; e.ext = ext;
    isa.push_back(e);
  endtask

  task automatic loadIsa();
    addIsa(6'h00, 6'h00, K_ALU, ALU_SLL, 2'b10, 1'b0);
    addIsa(6'h00, 6'h02, K_ALU, ALU_SRL, 2'b10, 1'b0);
    addIsa(6'h00, 6'h08, K_JR,  ALU_ADD, 2'b00, 1'b0);
    addIsa(6'h00, 6'h21, K_ALU, ALU_ADD, 2'b00, 1'b0);
    addIsa(6'h00, 6'h23, K_ALU, ALU_SUB, 2'b00, 1'b0);
    addIsa(6'h00, 6'h24, K_ALU, ALU_AND, 2'b00, 1'b0);
    addIsa(6'h00, 6'h25, K_ALU, ALU_OR,  2'b00, 1'b0);
    addIsa(6'h00, 6'h26, K_ALU, ALU_XOR, 2'b00, 1'b0);
    addIsa(6'h00, 6'h27, K_ALU, ALU_NOR, 2'b00, 1'b0);
    addIsa(6'h00, 6'h2A, K_ALU, ALU_SLT, 2'b00, 1'b0);
    addIsa(6'h00, 6'h2B, K_ALU, ALU_SLTU, 2'b00, 1'b0);
    addIsa(6'h09, 6'h00, K_ALU, ALU_ADD, 2'b01, 1'b1);
    addIsa(6'h0A, 6'h00, K_ALU, ALU_SLT, 2'b01, 1'b1);
    addIsa(6'h0B, 6'h00, K_ALU, ALU_SLTU, 2'b01, 1'b1);
    addIsa(6'h0C, 6'h00, K_ALU, ALU_AND, 2'b01, 1'b0);
    addIsa(6'h0D, 6'h00, K_ALU, ALU_OR,  2'b01, 1'b0);
    addIsa(6'h0E, 6'h00, K_ALU, ALU_XOR, 2'b01, 1'b0);
    addIsa(6'h0F, 6'h00, K_LUI, ALU_ADD, 2'b01, 1'b0);
    addIsa(6'h04, 6'h00, K_BEQ, ALU_SUB, 2'b00, 1'b1);
    addIsa(6'h05, 6'h00, K_BNE, ALU_SUB, 2'b00, 1'b1);
    addIsa(6'h23, 6'h00, K_LW,  ALU_ADD, 2'b01, 1'b1);
    addIsa(6'h2B, 6'h00, K_SW,  ALU_ADD, 2'b01, 1'b1);
    addIsa(6'h02, 6'h00, K_J,   ALU_ADD, 2'b00, 1'b0);
    addIsa(6'h03, 6'h00, K_JAL, ALU_ADD, 2'b00, 1'b0);
    addIsa(6'h3F, 6'h00, K_HALT, ALU_ADD, 2'b00, 1'b0);
  endtask

  function automatic isa_t lookup(input logic [31:0] ins);
    isa_t e;
    e = '0;
    e.kind = K_ILL;
    foreach (isa[i])
      if (isa[i].opc == ins[31:26] && (isa[i].opc != 6'h00 || isa[i].fn == ins[5:0])) e = isa[i];
    return e;
  endfunction

  task automatic push(input logic rstn, input logic ih, input logic dh, input logic z,
                      input logic [31:0] ins, input ctrl_t e);
    step_t s;
    s.rstn = rstn; s.ihit = ih; s.dhit = dh; s.zero = z; s.instr = ins; s.exp = e;
    plan.push_back(s);
  endtask

  task automatic absorb(input logic [31:0] ins, input logic [1:0] code);
    ctrl_t e;
    for (int i = 0; i < ABSORB_CYCLES; i++) begin
      e = '0; e.halt = 1'b1; e.err = code;
      push(1'b1, rnd(), rnd(), rnd(), ins, e);
    end
  endtask

  task automatic pushReset(input logic [1:0] code);
    ctrl_t e;
    e = '0; e.halt = 1'b1; e.err = code;
    push(1'b0, rnd(), rnd(), 1'b0, 32'h0, e);
  endtask

  task automatic idleFetch();
    ctrl_t e;
    e = '0; e.iREN = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, e);
  endtask

  // Expected trace: fetch wait/hit, decode, exec, optional memory wait/hit, write-back.
  task automatic buildInstr(input logic [31:0] ins, input int iDelay, input int dDelay,
                            input logic z, input int rstInMem);
    isa_t  d;
    ctrl_t e, ex;
    d = lookup(ins);
    ex = '0; ex.aluOp = d.alu; ex.aluSrc = d.src; ex.extOp = d.ext;
    for (int i = 0; i < iDelay && i <= LIMIT; i++) begin
      e = '0; e.iREN = 1'b1;
      push(1'b1, 1'b0, rnd(), z, ins, e);
    end
    if (iDelay > LIMIT) begin absorb(ins, 2'b01); return; end
    e = '0; e.iREN = 1'b1; e.IRWr = 1'b1; e.PCWr = 1'b1;
    push(1'b1, 1'b1, rnd(), z, ins, e);
    e = '0;
    if (d.kind == K_J || d.kind == K_JAL) begin e.PCWr = 1'b1; e.PCsrc = 2'b10; end
    if (d.kind == K_JAL) begin e.regWr = 1'b1; e.regDst = 2'b10; end
    push(1'b1, rnd(), rnd(), z, ins, e);
    if (d.kind == K_J || d.kind == K_JAL) return;
    if (d.kind == K_HALT) begin absorb(ins, 2'b00); return; end
    if (d.kind == K_ILL) begin absorb(ins, 2'b11); return; end
    e = ex;
    if (d.kind == K_BEQ) begin e.PCWr = z;  e.PCsrc = 2'b01; end
    if (d.kind == K_BNE) begin e.PCWr = ~z; e.PCsrc = 2'b01; end
    if (d.kind == K_JR)  begin e.PCWr = 1'b1; e.PCsrc = 2'b11; end
    push(1'b1, rnd(), rnd(), z, ins, e);
    if (d.kind == K_BEQ || d.kind == K_BNE || d.kind == K_JR) return;
    if (d.kind == K_LW || d.kind == K_SW) begin
      e = ex; e.dREN = (d.kind == K_LW); e.dWEN = (d.kind == K_SW);
      for (int i = 0; i < dDelay && i <= LIMIT; i++) begin
        if (i == rstInMem) begin push(1'b0, rnd(), 1'b0, z, ins, e); return; end
        push(1'b1, rnd(), 1'b0, z, ins, e);
      end
      if (dDelay > LIMIT) begin absorb(ins, 2'b10); return; end
      push(1'b1, rnd(), 1'b1, z, ins, e);
      if (d.kind == K_SW) return;
    end
    e = ex; e.regWr = 1'b1;
    e.regDst   = (ins[31:26] == 6'h00) ? 2'b01 : 2'b00;
    e.memToReg = (d.kind == K_LW);
    e.lui      = (d.kind == K_LUI);
    push(1'b1, rnd(), rnd(), z, ins, e);
  endtask

  task automatic applyStimulus(input step_t s);
    nRst = s.rstn; ihit = s.ihit; dhit = s.dhit; zero = s.zero; instr = s.instr;
  endtask

  task automatic checkOutput(input string tag, input ctrl_t exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic runPlan(input string tag);
    foreach (plan[i]) begin
      applyStimulus(plan[i]);
      @(negedge clk);
      checkOutput($sformatf("%s[%0d]", tag, i), plan[i].exp);
      @(posedge clk);
      #1;
    end
    plan.delete();
  endtask

  initial begin
    ctrl_t       e;
    logic [31:0] ins;
    int          idx;
    loadIsa();
    repeat (2) @(posedge clk);
    #1;
    e = '0; e.iREN = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e);
    runPlan("reset");

    buildInstr(32'h00221821, 2, 0, 1'b0, -1);  runPlan("addu");
    buildInstr(32'h8C220004, 0, 3, 1'b0, -1);  runPlan("lw");
    buildInstr(32'h10220003, 0, 0, 1'b1, -1);  runPlan("beq_taken");
    buildInstr(32'h10220003, 1, 0, 1'b0, -1);  runPlan("beq_not_taken");
    buildInstr(32'h14220003, 0, 0, 1'b0, -1);  runPlan("bne_taken");
    buildInstr(32'h24220010, LIMIT, 0, 1'b0, -1); runPlan("fetch_limit_hit");
    buildInstr(32'h8C220004, 0, LIMIT, 1'b0, -1); runPlan("mem_limit_hit");

    for (int n = 0; n < 60; n++) begin
      do idx = $urandom_range(0, isa.size() - 1); while (isa[idx].kind == K_HALT);
      ins = $urandom;
      ins[31:26] = isa[idx].opc;
      if (isa[idx].opc == 6'h00) ins[5:0] = isa[idx].fn;
      buildInstr(ins, $urandom_range(0, LIMIT), $urandom_range(0, LIMIT), rnd(), -1);
      runPlan($sformatf("rand%0d_%h", n, ins));
    end

    buildInstr(32'h00221821, LIMIT + 1, 0, 1'b0, -1); pushReset(2'b01); runPlan("fetch_timeout");
    buildInstr(32'h8C220004, 0, LIMIT + 1, 1'b0, -1); pushReset(2'b10); runPlan("mem_timeout");
    buildInstr(32'hF8000000, 0, 0, 1'b0, -1); pushReset(2'b11); runPlan("illegal_opcode");
    buildInstr(32'h00221820, 0, 0, 1'b0, -1); pushReset(2'b11); runPlan("illegal_funct");

    buildInstr(32'hFC000000, 1, 0, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      e = '0; e.halt = 1'b1;
      push(1'b1, 1'(i % 2), 1'b0, 1'b0, 32'hFC000000, e);
    end
    pushReset(2'b00);
    idleFetch();
    runPlan("halt");

    buildInstr(32'hAC220008, 0, 3, 1'b0, 2);
    idleFetch();
    runPlan("sw_reset_mid_access");
    buildInstr(32'h00221821, 0, 0, 1'b0, -1); runPlan("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
